// File: rtl/driver_motor_persiana_pkg.sv
// Shared types and constants for the blind motor driver: state codes, direction
// encoding and the debug state width used by the controller and the bench.
package persiana_pkg;

    localparam int ESTADO_W = 3;

    typedef enum logic [ESTADO_W-1:0] {
        PARADO   = 3'd0,
        ESPERA   = 3'd1,
        SUBIENDO = 3'd2,
        BAJANDO  = 3'd3,
        FALLO    = 3'd4
    } estado_t;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // Counter width for a terminal count of n, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return ($clog2(n) < 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/driver_motor_persiana_if.sv
// Request/motor-enable bundle between the blind controller (master) and the
// motor driver stage (slave).
interface driver_motor_persiana_if;
    import persiana_pkg::*;

    logic                subir;
    logic                bajar;
    logic                motor_sub;
    logic                motor_baj;
    logic                fallo;
    logic [ESTADO_W-1:0] estado;

    modport master (
        output subir, bajar,
        input  motor_sub, motor_baj, fallo, estado
    );

    modport slave (
        input  subir, bajar,
        output motor_sub, motor_baj, fallo, estado
    );

endinterface

// File: rtl/driver_motor_persiana_sincronizador_2ff.sv
// Two-flop synchronizer for an asynchronous level (limit switches), cleared by
// the asynchronous active-high reset.
module sincronizador_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/driver_motor_persiana.sv
// H-bridge driver for the blind motor: dead time before every start, limit-switch
// stop and, when PERSIANA_WATCHDOG_EN is defined, a travel watchdog latching FALLO.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// PARADO   | motor off, waiting for a valid UP/DOWN request
// ESPERA   | dead time running, both lines low, direction held in dir_q
// SUBIENDO | motor_sub on
// BAJANDO  | motor_baj on
// FALLO    | watchdog tripped, motor off until reset (watchdog build only)
module driver_motor_persiana
    import persiana_pkg::*;
#(
    parameter int DEAD_CYCLES    = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                    Reloj,
    input  logic                    reset,
    input  logic                    Ssup,
    input  logic                    Sinf,
    driver_motor_persiana_if.slave  bus
);

    localparam int             DW        = cnt_w(DEAD_CYCLES);
    localparam logic [DW-1:0]  DEAD_INIT = DW'(DEAD_CYCLES - 1);

    if (DEAD_CYCLES < 2 || TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("driver_motor_persiana: DEAD_CYCLES must be >= 2 and TIMEOUT_CYCLES >= 1");
    end

    logic ssup_s;
    logic sinf_s;

    sincronizador_2ff u_sync_ssup (.clk(Reloj), .rst(reset), .d(Ssup), .q(ssup_s));
    sincronizador_2ff u_sync_sinf (.clk(Reloj), .rst(reset), .d(Sinf), .q(sinf_s));

    estado_t       state_q, state_d;
    logic          dir_q, dir_d;
    logic [DW-1:0] dead_q, dead_d;
    logic          motor_sub_q, motor_sub_d;
    logic          motor_baj_q, motor_baj_d;

`ifdef PERSIANA_WATCHDOG_EN
    localparam int             RW      = cnt_w(TIMEOUT_CYCLES);
    localparam logic [RW-1:0]  RUN_MAX = RW'(TIMEOUT_CYCLES - 1);

    logic [RW-1:0] run_q, run_d;
    logic          fallo_q, fallo_d;
`endif

    logic req_up;
    logic req_down;
    logic req_match;
    logic lim_dir;

    assign req_up    = bus.subir & ~bus.bajar;
    assign req_down  = bus.bajar & ~bus.subir;
    assign req_match = dir_q ? req_up : req_down;
    assign lim_dir   = dir_q ? ssup_s : sinf_s;

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        dead_d  = dead_q;
`ifdef PERSIANA_WATCHDOG_EN
        run_d   = run_q;
`endif
        case (state_q)
            PARADO: begin
                if (req_up && !ssup_s) begin
                    state_d = ESPERA;
                    dir_d   = DIR_UP;
                    dead_d  = DEAD_INIT;
                end else if (req_down && !sinf_s) begin
                    state_d = ESPERA;
                    dir_d   = DIR_DOWN;
                    dead_d  = DEAD_INIT;
                end
            end
            ESPERA: begin
                if (!req_match || lim_dir) begin
                    state_d = PARADO;
                end else if (dead_q == '0) begin
                    if (dir_q == DIR_UP) state_d = SUBIENDO;
                    else                 state_d = BAJANDO;
`ifdef PERSIANA_WATCHDOG_EN
                    run_d = '0;
`endif
                end else begin
                    dead_d = dead_q - 1'b1;
                end
            end
            // Limit/request checks come before the watchdog so a coincident
            // limit switch ends in PARADO rather than FALLO.
            SUBIENDO: begin
                if (!req_up || ssup_s) begin
                    state_d = PARADO;
`ifdef PERSIANA_WATCHDOG_EN
                end else if (run_q == RUN_MAX) begin
                    state_d = FALLO;
                end else begin
                    run_d = run_q + 1'b1;
`endif
                end
            end
            BAJANDO: begin
                if (!req_down || sinf_s) begin
                    state_d = PARADO;
`ifdef PERSIANA_WATCHDOG_EN
                end else if (run_q == RUN_MAX) begin
                    state_d = FALLO;
                end else begin
                    run_d = run_q + 1'b1;
`endif
                end
            end
`ifdef PERSIANA_WATCHDOG_EN
            FALLO:   state_d = FALLO;
`endif
            default: state_d = PARADO;
        endcase

        // Outputs are decoded from the next state so the registered lines
        // always equal the decode of the registered state.
        motor_sub_d = (state_d == SUBIENDO);
        motor_baj_d = (state_d == BAJANDO);
`ifdef PERSIANA_WATCHDOG_EN
        fallo_d     = (state_d == FALLO);
`endif
    end

    always_ff @(posedge Reloj or posedge reset) begin
        if (reset) begin
            state_q     <= PARADO;
            dir_q       <= DIR_DOWN;
            dead_q      <= '0;
            motor_sub_q <= 1'b0;
            motor_baj_q <= 1'b0;
`ifdef PERSIANA_WATCHDOG_EN
            run_q       <= '0;
            fallo_q     <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            dir_q       <= dir_d;
            dead_q      <= dead_d;
            motor_sub_q <= motor_sub_d;
            motor_baj_q <= motor_baj_d;
`ifdef PERSIANA_WATCHDOG_EN
            run_q       <= run_d;
            fallo_q     <= fallo_d;
`endif
        end
    end

    assign bus.motor_sub = motor_sub_q;
    assign bus.motor_baj = motor_baj_q;
    assign bus.estado    = state_q;
`ifdef PERSIANA_WATCHDOG_EN
    assign bus.fallo     = fallo_q;
`else
    assign bus.fallo     = 1'b0;
`endif

endmodule

// File: tb/tb_driver_motor_persiana.sv
// Directed bench for driver_motor_persiana with DEAD_CYCLES=4, TIMEOUT_CYCLES=20;
// watchdog expectations follow PERSIANA_WATCHDOG_EN.
module tb_driver_motor_persiana;

    localparam int DEAD = 4;
    localparam int TOUT = 20;

    logic Reloj = 1'b0;
    logic reset;
    logic Ssup;
    logic Sinf;

    int n_checks = 0;
    int n_err    = 0;

    driver_motor_persiana_if bus ();

    driver_motor_persiana #(
        .DEAD_CYCLES   (DEAD),
        .TIMEOUT_CYCLES(TOUT)
    ) dut (
        .Reloj(Reloj),
        .reset(reset),
        .Ssup (Ssup),
        .Sinf (Sinf),
        .bus  (bus)
    );

    always #5 Reloj = ~Reloj;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_out(input string tag, input logic ms, input logic mb,
                             input logic fl, input logic [2:0] st);
        check_val({tag, ".motor_sub"}, 32'(bus.motor_sub), 32'(ms));
        check_val({tag, ".motor_baj"}, 32'(bus.motor_baj), 32'(mb));
        check_val({tag, ".fallo"},     32'(bus.fallo),     32'(fl));
        check_val({tag, ".estado"},    32'(bus.estado),    32'(st));
    endtask

    // One clock edge, then sample 1 ns later; the two lines must never overlap.
    task automatic tick();
        @(posedge Reloj);
        #1;
        check_val("excl", 32'(bus.motor_sub & bus.motor_baj), 32'd0);
    endtask

    initial begin
        reset     = 1'b1;
        Ssup      = 1'b0;
        Sinf      = 1'b0;
        bus.subir = 1'b0;
        bus.bajar = 1'b0;
        #2;
        check_out("reset", 0, 0, 0, 3'd0);
        @(posedge Reloj);
        #1;
        reset = 1'b0;
        tick();
        tick();
        check_out("idle", 0, 0, 0, 3'd0);

        // Start: sampled at edge k, motor on after edge k+DEAD.
        bus.subir = 1'b1;
        tick();
        check_out("start_k", 0, 0, 0, 3'd1);
        for (int i = 1; i < DEAD; i++) begin
            tick();
            check_out("start_dead", 0, 0, 0, 3'd1);
        end
        tick();
        check_out("start_run", 1, 0, 0, 3'd2);
        tick();
        tick();

        // Reversal: low after k, opposite line after k+1+DEAD.
        bus.subir = 1'b0;
        bus.bajar = 1'b1;
        tick();
        check_out("rev_stop", 0, 0, 0, 3'd0);
        tick();
        check_out("rev_wait", 0, 0, 0, 3'd1);
        for (int i = 1; i < DEAD; i++) begin
            tick();
            check_out("rev_dead", 0, 0, 0, 3'd1);
        end
        tick();
        check_out("rev_run", 0, 1, 0, 3'd3);
        tick();

        // Lower limit: synchronizer delay of two edges, stop on the third.
        Sinf = 1'b1;
        tick();
        check_out("sinf_e1", 0, 1, 0, 3'd3);
        tick();
        check_out("sinf_e2", 0, 1, 0, 3'd3);
        tick();
        check_out("sinf_e3", 0, 0, 0, 3'd0);
        for (int i = 0; i < 6; i++) begin
            tick();
            check_out("sinf_hold", 0, 0, 0, 3'd0);
        end
        bus.bajar = 1'b0;
        Sinf      = 1'b0;
        repeat (3) tick();

        // Both requests high decode as STOP.
        bus.subir = 1'b1;
        bus.bajar = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_out("both", 0, 0, 0, 3'd0);
        end
        bus.subir = 1'b0;
        bus.bajar = 1'b0;
        tick();

        // Short pulse aborts the dead time without a motor pulse.
        bus.subir = 1'b1;
        tick();
        check_out("pulse_1", 0, 0, 0, 3'd1);
        tick();
        check_out("pulse_2", 0, 0, 0, 3'd1);
        bus.subir = 1'b0;
        for (int i = 0; i < DEAD + 2; i++) begin
            tick();
            check_out("pulse_off", 0, 0, 0, 3'd0);
        end

        // Watchdog: long continuous raise.
        bus.subir = 1'b1;
        repeat (DEAD) tick();
        tick();
        check_out("wd_start", 1, 0, 0, 3'd2);
        for (int i = 1; i < TOUT; i++) begin
            tick();
            check_out("wd_run", 1, 0, 0, 3'd2);
        end
        for (int i = 0; i < 10; i++) begin
            tick();
`ifdef PERSIANA_WATCHDOG_EN
            check_out("wd_fault", 0, 0, 1, 3'd4);
`else
            check_out("wd_nofault", 1, 0, 0, 3'd2);
`endif
        end
        bus.subir = 1'b0;
        bus.bajar = 1'b1;
        for (int i = 0; i < DEAD + 2; i++) begin
            tick();
`ifdef PERSIANA_WATCHDOG_EN
            check_out("wd_latched", 0, 0, 1, 3'd4);
`else
            if (i == 0) check_out("wd_nf_stop", 0, 0, 0, 3'd0);
`endif
        end

        // Reset clears the fault; then asynchronous reset mid-BAJANDO.
        bus.bajar = 1'b0;
        reset = 1'b1;
        #1;
        check_out("rst_clear", 0, 0, 0, 3'd0);
        #1;
        reset = 1'b0;
        tick();
        bus.bajar = 1'b1;
        repeat (DEAD) tick();
        tick();
        check_out("rst_run", 0, 1, 0, 3'd3);
        #3;
        reset = 1'b1;
        #1;
        check_out("rst_async", 0, 0, 0, 3'd0);
        #2;
        reset     = 1'b0;
        bus.bajar = 1'b0;
        tick();
        check_out("rst_after", 0, 0, 0, 3'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/driver_motor_persiana.md
# driver_motor_persiana

Motor-driver stage directly downstream of the blind controller: consumes its `subir`/`bajar` requests and produces the actual motor-enable lines. It enforces a dead time before any motor start or direction change, and a hard stop on the limit switches. It also runs a travel watchdog that latches a fault if the motor runs too long. All motor outputs are registered; the block is the only path from control logic to the H-bridge.

## Interface
- `DEAD_CYCLES`, 16: cycles both motor lines are held low before any start; legal range ≥ 2.
- `TIMEOUT_CYCLES`, 1024: maximum continuous run cycles before fault; legal range ≥ 1.
- `Reloj`  input  1  system clock, rising-edge.
- `reset`  input  1  asynchronous, active-high reset.
- `subir`  input  1  raise request from the controller, synchronous to `Reloj`.
- `bajar`  input  1  lower request from the controller, synchronous to `Reloj`.
- `Ssup`  input  1  upper limit switch, active-high, asynchronous.
- `Sinf`  input  1  lower limit switch, active-high, asynchronous.
- `motor_sub`  output  1  H-bridge raise enable, registered.
- `motor_baj`  output  1  H-bridge lower enable, registered.
- `fallo`  output  1  watchdog fault flag, registered.
- `estado`  output  3  current state code, for debug.

## Operation
- `Ssup`/`Sinf` pass through 2-flop synchronizers; the synchronized values `ssup_s`/`sinf_s` are used everywhere below.
- Request decode:
  - UP = `subir & ~bajar`.
  - DOWN = `bajar & ~subir`.
  - Both high or both low = STOP.
- States (codes): PARADO=0, ESPERA=1, SUBIENDO=2, BAJANDO=3, FALLO=4.
- PARADO:
  - On UP with `!ssup_s`: go to ESPERA, dir=UP, dead counter = DEAD_CYCLES-1.
  - On DOWN with `!sinf_s`: go to ESPERA, dir=DOWN, dead counter = DEAD_CYCLES-1.
  - Otherwise stay in PARADO.
- ESPERA:
  - Both motor lines low; dead counter decrements each cycle.
  - If the request no longer matches dir, or the limit switch in dir is asserted: go to PARADO.
  - When the counter is 0 and the request still matches: go to SUBIENDO/BAJANDO, run counter cleared.
- SUBIENDO:
  - If the request is not UP, or `ssup_s` is asserted: go to PARADO.
  - A reversal (DOWN) therefore always passes through PARADO → ESPERA, giving a full dead time.
- BAJANDO: symmetric to SUBIENDO, using DOWN and `sinf_s`.
- Run counter increments each cycle in SUBIENDO/BAJANDO. Reaching TIMEOUT_CYCLES-1 goes to FALLO.
- FALLO:
  - Motor lines low, `fallo`=1.
  - Exits only on `reset`; requests are ignored.
- Outputs decoded from the registered state:
  - `motor_sub` = (state==SUBIENDO).
  - `motor_baj` = (state==BAJANDO).
  - `fallo` = (state==FALLO).
- `motor_sub` and `motor_baj` are never high in the same cycle.
- Counter widths: `$clog2(DEAD_CYCLES)` and `$clog2(TIMEOUT_CYCLES)`, minimum 1 bit. Counters saturate and never wrap.

## Timing
- Reset (asynchronous, immediate):
  - State = PARADO; all outputs 0.
  - Synchronizers and counters cleared.
  - Reset asserted mid-run drops the motor lines in the same cycle.
- Start latency: request sampled at edge k in PARADO; motor line high after edge k+DEAD_CYCLES.
- Stop latency:
  - Request removed: motor line low after the next edge.
  - Limit switch: at most 3 edges after the switch asserts (2 synchronizer + 1 state).
- Reversal: motor line low at k+1; opposite line high at k+1+DEAD_CYCLES.
- DEAD_CYCLES ≥ 2 guarantees the synchronizers settle after reset before any motor start.
- Watchdog: FALLO after exactly TIMEOUT_CYCLES cycles of continuous run.
- Simultaneous events: a limit switch and a watchdog expiry in the same cycle resolve to PARADO (limit wins).

## Configuration
- `PERSIANA_WATCHDOG_EN` defined: run counter, FALLO state and watchdog behaviour present as above.
- Not defined:
  - No run counter and no FALLO state; code 4 is unreachable.
  - `fallo` tied to 0.
  - The motor runs until the request drops or a limit switch asserts.

## Structure
- `persiana_pkg` holds:
  - the state codes;
  - direction encoding (UP=1, DOWN=0);
  - the `estado` width constant, shared with the controller and the testbench.
- One sub-module, `sincronizador_2ff`, instantiated twice (`Ssup`, `Sinf`), with asynchronous active-high reset to 0.

## Test plan
Bench parameters: DEAD_CYCLES=4, TIMEOUT_CYCLES=20, watchdog enabled unless noted.
- Raise `subir` at edge 10 → `motor_sub`=1 from edge 14; `motor_baj` stays 0 throughout.
- While SUBIENDO, switch to `bajar` at edge 30 → `motor_sub`=0 at 31; `motor_baj`=1 at 35; both lines never high together.
- While BAJANDO, assert `Sinf` at edge 50 → `motor_baj`=0 by edge 53; holding `bajar` does not restart the motor while `Sinf` stays high.
- Hold `subir` with `Ssup` low for 30 cycles → `fallo`=1 exactly 20 cycles after `motor_sub` rose; outputs stay 0/0/1 until `reset`. Without the macro, `fallo` stays 0 and the motor stays on.
- `subir`=`bajar`=1 → stays in PARADO; `subir` pulsed for 2 cycles → returns from ESPERA to PARADO with no motor pulse.
- Assert `reset` mid-BAJANDO → `motor_baj`=0 before the next clock edge, `estado`=0.
